t02_load_store_unit: RTL and testbench

// - Memory-access stage directly downstream of t02_alu in the single-cycle RISC-V core.
// - Consumes ALUResult as the effective address for loads and stores.
// - Runs a req/ack bus transaction and stalls the PC until that transaction completes.
// - Performs byte/half lane steering for stores and sign/zero extension for loads.

---
 rtl/t02_load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_t02_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/t02_load_store_unit.sv
// Memory-access stage: req/ack bus transaction with byte/half lane steering and load extension.
// Latency: ack delay + 2 cycles (request cycle, BUSY cycles, one DONE cycle); stall held until DONE.
// Backpressure: the bus stretches BUSY via bus_ack; abort after TIMEOUT_CYCLES. Option: T02_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module t02_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        misaligned
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] cnt;
    logic        err_q;
    logic        req;
    logic [3:0]  sel_n;
    logic [31:0] wdata_n;
    logic [31:0] rshift;
    logic [15:0] half_sel;
    logic [31:0] ext_data;
    logic        mis_n;

    assign req = mem_read | mem_write;

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    always_comb begin
        sel_n   = 4'b1111;
        wdata_n = store_data;
        case (funct3[1:0])
            2'b00: begin
                sel_n   = 4'b0001 << alu_result[1:0];
                wdata_n = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel_n   = 4'b0011 << {alu_result[1], 1'b0};
                wdata_n = {2{store_data[15:0]}};
            end
            default: begin
                sel_n   = 4'b1111;
                wdata_n = store_data;
            end
        endcase
    end

    always_comb begin
        rshift   = bus_rdata >> {lane_q, 3'b000};
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext_data = bus_rdata;
        case (f3_q[1:0])
            2'b00:   ext_data = {{24{rshift[7] & ~f3_q[2]}}, rshift[7:0]};
            2'b01:   ext_data = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
            default: ext_data = bus_rdata;
        endcase
    end

`ifdef T02_MISALIGN_TRAP_EN
    logic mis_q;

    assign mis_n      = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                        (funct3[1] & (alu_result[1:0] != 2'b00));
    assign misaligned = (state == DONE) & mis_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            mis_q <= 1'b0;
        end else if (state == IDLE && req) begin
            mis_q <= mis_n;
        end
    end
`else
    assign mis_n      = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_sel   <= 4'h0;
            load_data <= 32'h0;
            f3_q      <= 3'h0;
            lane_q    <= 2'h0;
            cnt       <= 16'h0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        err_q <= 1'b0;
                        cnt   <= 16'h0;
                        if (mis_n) begin
                            // trapped access: skip the bus entirely
                            load_data <= 32'h0;
                            state     <= DONE;
                        end else begin
                            bus_wen   <= mem_write;
                            bus_ren   <= mem_read & ~mem_write;
                            bus_addr  <= {alu_result[31:2], 2'b00};
                            bus_sel   <= sel_n;
                            bus_wdata <= wdata_n;
                            f3_q      <= funct3;
                            lane_q    <= alu_result[1:0];
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (bus_ren) begin
                            load_data <= ext_data;
                        end
                        bus_ren <= 1'b0;
                        bus_wen <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == TO_LAST) begin
                        bus_ren   <= 1'b0;
                        bus_wen   <= 1'b0;
                        load_data <= 32'h0;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 16'h1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // gated by nRst so the PC is released the instant reset aborts a transaction
    assign stall = nRst & (((state == IDLE) & req) | (state == BUSY));
    assign done  = (state == DONE);
    assign err   = (state == DONE) & err_q;

endmodule

// File: tb/tb_t02_load_store_unit.sv
// Directed bench for t02_load_store_unit: vector table of single accesses plus
// hand sequences for ack latency, timeout, reset abort and misaligned accesses.
`timescale 1ns/1ps
module tb_t02_load_store_unit;

    logic        clk = 1'b0;
    logic        nRst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        bus_ren, bus_wen;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] load_data;
    logic        stall, done, err, misaligned;

    int checks = 0;
    int errors = 0;

    t02_load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .nRst(nRst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .load_data(load_data), .stall(stall), .done(done),
        .err(err), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
    } vec_t;

    vec_t vecs[12];

    // results of the most recent do_txn
    int          t_stall, t_busy;
    logic        t_done, t_err, t_mis, t_moved, t_strobe_end;
    logic        t_ren, t_wen;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_sel;
    logic [31:0] last_load;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one access; ack_at = index of the BUSY cycle carrying bus_ack (0 = never)
    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int ack_at);
        bit seen;
        seen = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = a; store_data = sd; bus_rdata = rdat; bus_ack = 1'b0;
        #1;
        t_stall = 0; t_busy = 0; t_done = 0; t_err = 0; t_mis = 0;
        t_moved = 0; t_strobe_end = 0; t_ren = 0; t_wen = 0;
        t_addr = 32'h0; t_wdata = 32'h0; t_sel = 4'h0;
        for (int n = 0; n < 400 && !t_done; n++) begin
            if (stall) t_stall++;
            if (done) begin
                t_done = 1; t_err = err; t_mis = misaligned;
                t_strobe_end = bus_ren | bus_wen;
            end else begin
                if (bus_ren | bus_wen) begin
                    t_busy++;
                    if (!seen) begin
                        seen = 1;
                        t_ren = bus_ren; t_wen = bus_wen;
                        t_addr = bus_addr; t_sel = bus_sel; t_wdata = bus_wdata;
                    end else if (bus_addr !== t_addr || bus_sel !== t_sel ||
                                 bus_wdata !== t_wdata || bus_ren !== t_ren ||
                                 bus_wen !== t_wen) begin
                        t_moved = 1;
                    end
                    bus_ack = (t_busy == ack_at);
                end else begin
                    bus_ack = 1'b0;
                end
                @(negedge clk);
                #1;
            end
        end
        bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (!t_done) begin
            checks++; errors++;
            $display("FAIL done_bound no done within 400 cycles got 0 want 1");
        end
    endtask

    initial begin
        //            rd wr  f3     addr          sdata         rdata         e_addr        e_sel    e_wdata       e_load
        vecs[0]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80123456, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80123456, 32'h100, 4'b1000, 32'h0,        32'h00000080};
        vecs[2]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80123456, 32'h100, 4'b1100, 32'h0,        32'h00008012};
        vecs[3]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80123456, 32'h100, 4'b1100, 32'h0,        32'hFFFF8012};
        vecs[4]  = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h80123456, 32'h100, 4'b0010, 32'h0,        32'h00000034};
        vecs[5]  = '{1, 0, 3'b001, 32'h100, 32'h0,        32'h1234F00D, 32'h100, 4'b0011, 32'h0,        32'hFFFFF00D};
        vecs[6]  = '{0, 1, 3'b000, 32'h205, 32'h000000A5, 32'hBAD0BAD0, 32'h204, 4'b0010, 32'hA5A5A5A5, 32'hFFFFF00D};
        vecs[7]  = '{0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'hBAD0BAD0, 32'h200, 4'b1100, 32'hABCDABCD, 32'hFFFFF00D};
        vecs[8]  = '{0, 1, 3'b010, 32'h300, 32'h12345678, 32'hBAD0BAD0, 32'h300, 4'b1111, 32'h12345678, 32'hFFFFF00D};
        vecs[9]  = '{1, 1, 3'b010, 32'h040, 32'hCAFEF00D, 32'hBAD0BAD0, 32'h040, 4'b1111, 32'hCAFEF00D, 32'hFFFFF00D};
        vecs[10] = '{1, 0, 3'b011, 32'h044, 32'h0,        32'h89ABCDEF, 32'h044, 4'b1111, 32'h0,        32'h89ABCDEF};
        vecs[11] = '{1, 0, 3'b110, 32'h048, 32'h0,        32'h00C0FFEE, 32'h048, 4'b1111, 32'h0,        32'h00C0FFEE};

        nRst = 1'b0; mem_read = 0; mem_write = 0; funct3 = 3'b0;
        alu_result = 32'h0; store_data = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        #12;
        chk("rst_ren", {31'h0, bus_ren}, 32'h0);
        chk("rst_wen", {31'h0, bus_wen}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        @(negedge clk);
        nRst = 1'b1;

        // stray ack while idle must be ignored
        @(negedge clk); bus_ack = 1'b1;
        @(negedge clk); bus_ack = 1'b0; #1;
        chk("idle_ack_done", {31'h0, done}, 32'h0);
        chk("idle_ack_ren", {31'h0, bus_ren}, 32'h0);

        // LW 0x100, ack in the third BUSY cycle
        do_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        chk("t1_addr", t_addr, 32'h100);
        chk("t1_sel", {28'h0, t_sel}, 32'hF);
        chk("t1_stall", t_stall, 4);
        chk("t1_busy", t_busy, 3);
        chk("t1_load", load_data, 32'hDEADBEEF);
        chk("t1_err", {31'h0, t_err}, 32'h0);
        @(negedge clk); #1;
        chk("t1_done_pulse", {31'h0, done}, 32'h0);
        chk("t1_stall_after", {31'h0, stall}, 32'h0);
        last_load = 32'hDEADBEEF;

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                   vecs[i].sdata, vecs[i].rdata, 1);
            chk($sformatf("v%0d_addr", i), t_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_sel", i), {28'h0, t_sel}, {28'h0, vecs[i].e_sel});
            chk($sformatf("v%0d_wen", i), {31'h0, t_wen}, {31'h0, vecs[i].wr});
            chk($sformatf("v%0d_ren", i), {31'h0, t_ren}, {31'h0, vecs[i].rd & ~vecs[i].wr});
            if (vecs[i].wr)
                chk($sformatf("v%0d_wdata", i), t_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_load", i), load_data, vecs[i].e_load);
            chk($sformatf("v%0d_stall", i), t_stall, 2);
            chk($sformatf("v%0d_strobe_end", i), {31'h0, t_strobe_end}, 32'h0);
        end

        // SH held constant over several BUSY cycles
        do_txn(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 5);
        chk("t3_busy", t_busy, 5);
        chk("t3_wen", {31'h0, t_wen}, 32'h1);
        chk("t3_held", {31'h0, t_moved}, 32'h0);
        chk("t3_wdata", t_wdata, 32'hABCDABCD);

        // reset in the middle of BUSY aborts the load
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h180; bus_ack = 1'b0;
        @(negedge clk); #1;
        chk("t5_busy_ren", {31'h0, bus_ren}, 32'h1);
        @(negedge clk); #2;
        nRst = 1'b0; #1;
        chk("t5_ren", {31'h0, bus_ren}, 32'h0);
        chk("t5_wen", {31'h0, bus_wen}, 32'h0);
        chk("t5_stall", {31'h0, stall}, 32'h0);
        chk("t5_done", {31'h0, done}, 32'h0);
        chk("t5_load", load_data, 32'h0);
        @(negedge clk);
        mem_read = 1'b0; nRst = 1'b1;
        @(negedge clk); #1;
        chk("t5_no_done", {31'h0, done}, 32'h0);
        do_txn(0, 1, 3'b010, 32'h10, 32'h55AA33CC, 32'h0, 2);
        chk("t5_sw_addr", t_addr, 32'h10);
        chk("t5_sw_sel", {28'h0, t_sel}, 32'hF);
        chk("t5_sw_wdata", t_wdata, 32'h55AA33CC);
        chk("t5_sw_err", {31'h0, t_err}, 32'h0);

        // LW 0x102: trapped or word-aligned depending on build
        do_txn(1, 0, 3'b010, 32'h102, 32'h0, 32'h13579BDF, 1);
`ifdef T02_MISALIGN_TRAP_EN
        chk("t6_busy", t_busy, 0);
        chk("t6_mis", {31'h0, t_mis}, 32'h1);
        chk("t6_load", load_data, 32'h0);
        chk("t6_stall", t_stall, 1);
`else
        chk("t6_addr", t_addr, 32'h100);
        chk("t6_mis", {31'h0, t_mis}, 32'h0);
        chk("t6_load", load_data, 32'h13579BDF);
        chk("t6_stall", t_stall, 2);
`endif

        // LW with no ack: abort after 255 BUSY cycles
        do_txn(1, 0, 3'b010, 32'h80, 32'h0, 32'hFFFFFFFF, 0);
        chk("t4_busy", t_busy, 255);
        chk("t4_err", {31'h0, t_err}, 32'h1);
        chk("t4_ren_end", {31'h0, t_strobe_end}, 32'h0);
        chk("t4_load", load_data, 32'h0);
        @(negedge clk); #1;
        chk("t4_err_clear", {31'h0, err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
